// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard sequencer: register index and
// sequencer state encoding.
package pipeline_hazard_ctrl_pkg;

    typedef logic [4:0] regbits_t;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        DMEM_WAIT  = 2'd1,
        HALT_DRAIN = 2'd2,
        HALTED     = 2'd3
    } hzstate_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Handshake between the hazard sequencer and the pipeline datapath:
// hazard sources flow in, latch enables/flushes and PC enable flow out.
interface pipeline_hazard_ctrl_if;
    import pipeline_hazard_ctrl_pkg::*;

    logic     ihit;
    logic     dhit;
    logic     dREN_mem;
    logic     dWEN_mem;
    logic     dREN_ex;
    regbits_t regWSEL_ex;
    regbits_t rs_dec;
    regbits_t rt_dec;
    logic     rt_used_dec;
    logic     redirect_mem;
    logic     halt_mem;

    logic     pc_en;
    logic     en_fd;
    logic     en_de;
    logic     en_em;
    logic     en_mw;
    logic     flush_fd;
    logic     flush_de;
    logic     flush_em;
    logic     flush_mw;

    // Sequencer side: consumes hazard sources, drives latch controls.
    modport master (
        input  ihit, dhit, dREN_mem, dWEN_mem, dREN_ex, regWSEL_ex,
               rs_dec, rt_dec, rt_used_dec, redirect_mem, halt_mem,
        output pc_en, en_fd, en_de, en_em, en_mw,
               flush_fd, flush_de, flush_em, flush_mw
    );

    // Datapath side: reports hazard sources, obeys latch controls.
    modport slave (
        output ihit, dhit, dREN_mem, dWEN_mem, dREN_ex, regWSEL_ex,
               rs_dec, rt_dec, rt_used_dec, redirect_mem, halt_mem,
        input  pc_en, en_fd, en_de, en_em, en_mw,
               flush_fd, flush_de, flush_em, flush_mw
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Load-use hazard detector: a load in EX whose destination feeds a source
// operand of the instruction in DEC. $0 is never a real dependency.
module load_use_detect
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic     dREN_ex,
    input  regbits_t regWSEL_ex,
    input  regbits_t rs,
    input  regbits_t rt,
    input  logic     rt_used,
    output logic     hazard
);

    // Compare EX destination against the DEC operands actually read.
    always_comb begin
        hazard = dREN_ex && (regWSEL_ex != '0) &&
                 ((regWSEL_ex == rs) || (rt_used && (regWSEL_ex == rt)));
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central sequencer for the FD/DE/EM/MW pipeline latches and the PC.
// Latch controls are same-cycle combinational; halted and the stall
// counter are registered.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned STALL_W = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    pipeline_hazard_ctrl_if.master hz,
    output logic                  halted,
    output logic [STALL_W-1:0]    stall_cnt
);

    hzstate_t state;
    hzstate_t nextState;
    logic     loadUse;
    logic     dmemMiss;

    load_use_detect uLoadUse (
        .dREN_ex    (hz.dREN_ex),
        .regWSEL_ex (hz.regWSEL_ex),
        .rs         (hz.rs_dec),
        .rt         (hz.rt_dec),
        .rt_used    (hz.rt_used_dec),
        .hazard     (loadUse)
    );

    assign dmemMiss = (hz.dREN_mem || hz.dWEN_mem) && !hz.dhit;

    // Priority mux: pick latch enables/flushes and next state from hazards.
    always_comb begin
        nextState   = state;
        hz.pc_en    = 1'b0;
        hz.en_fd    = 1'b0;
        hz.en_de    = 1'b0;
        hz.en_em    = 1'b0;
        hz.en_mw    = 1'b0;
        hz.flush_fd = 1'b0;
        hz.flush_de = 1'b0;
        hz.flush_em = 1'b0;
        hz.flush_mw = 1'b0;

        if (RST) begin
            nextState   = RUN;
            hz.flush_fd = 1'b1;
            hz.flush_de = 1'b1;
            hz.flush_em = 1'b1;
            hz.flush_mw = 1'b1;
        end else begin
            unique case (state)
                // DMEM_WAIT shares RUN's priority chain: dhit=1 drops the miss
                // term, so the release cycle falls through to a full advance.
                RUN, DMEM_WAIT: begin
                    if (hz.halt_mem) begin
                        hz.flush_fd = 1'b1;
                        hz.flush_de = 1'b1;
                        hz.flush_em = 1'b1;
                        hz.en_mw    = 1'b1;
                        nextState   = HALT_DRAIN;
                    end else if (dmemMiss) begin
                        hz.en_mw    = 1'b1;
                        hz.flush_mw = 1'b1;
                        nextState   = DMEM_WAIT;
                    end else begin
                        nextState = RUN;
                        if (hz.redirect_mem) begin
                            hz.pc_en    = 1'b1;
                            hz.flush_fd = 1'b1;
                            hz.flush_de = 1'b1;
                            hz.flush_em = 1'b1;
                            hz.en_mw    = 1'b1;
                        end else if (loadUse || !hz.ihit) begin
                            hz.flush_de = 1'b1;
                            hz.en_em    = 1'b1;
                            hz.en_mw    = 1'b1;
                        end else begin
                            hz.pc_en = 1'b1;
                            hz.en_fd = 1'b1;
                            hz.en_de = 1'b1;
                            hz.en_em = 1'b1;
                            hz.en_mw = 1'b1;
                        end
                    end
                end
                HALT_DRAIN: begin
                    hz.en_mw  = 1'b1;
                    nextState = HALTED;
                end
                HALTED: begin
                    nextState = HALTED;
                end
                default: begin
                    nextState = RUN;
                end
            endcase
        end
    end

    // State register, sticky halt flag and saturating stall counter.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= RUN;
            halted    <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state  <= nextState;
            halted <= (nextState == HALTED);
            if (!hz.pc_en && (state != HALTED) && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: hand-computed control vectors
// for each hazard case, plus a narrow-counter instance for saturation.
module tb_pipeline_hazard_ctrl;
    import pipeline_hazard_ctrl_pkg::*;

    // Control vector: {pc_en, en_fd, en_de, en_em, en_mw,
    //                  flush_fd, flush_de, flush_em, flush_mw}
    localparam logic [8:0] V_RESET  = 9'b0_0000_1111;
    localparam logic [8:0] V_RUN    = 9'b1_1111_0000;
    localparam logic [8:0] V_BUBBLE = 9'b0_0011_0100;
    localparam logic [8:0] V_DMISS  = 9'b0_0001_0001;
    localparam logic [8:0] V_REDIR  = 9'b1_0001_1110;
    localparam logic [8:0] V_HALT   = 9'b0_0001_1110;
    localparam logic [8:0] V_DRAIN  = 9'b0_0001_0000;
    localparam logic [8:0] V_IDLE   = 9'b0_0000_0000;

    logic     CLK = 1'b0;
    logic     RST;
    logic     ihit, dhit, dREN_mem, dWEN_mem, dREN_ex, rt_used_dec;
    logic     redirect_mem, halt_mem;
    regbits_t regWSEL_ex, rs_dec, rt_dec;

    logic        halted, halted4;
    logic [15:0] stallCnt;
    logic [3:0]  stallCnt4;

    int unsigned checkCount = 0;
    int unsigned errorCount = 0;

    pipeline_hazard_ctrl_if hzIf ();
    pipeline_hazard_ctrl_if hzIf4 ();

    assign hzIf.ihit          = ihit;
    assign hzIf.dhit          = dhit;
    assign hzIf.dREN_mem      = dREN_mem;
    assign hzIf.dWEN_mem      = dWEN_mem;
    assign hzIf.dREN_ex       = dREN_ex;
    assign hzIf.regWSEL_ex    = regWSEL_ex;
    assign hzIf.rs_dec        = rs_dec;
    assign hzIf.rt_dec        = rt_dec;
    assign hzIf.rt_used_dec   = rt_used_dec;
    assign hzIf.redirect_mem  = redirect_mem;
    assign hzIf.halt_mem      = halt_mem;
    assign hzIf4.ihit         = ihit;
    assign hzIf4.dhit         = dhit;
    assign hzIf4.dREN_mem     = dREN_mem;
    assign hzIf4.dWEN_mem     = dWEN_mem;
    assign hzIf4.dREN_ex      = dREN_ex;
    assign hzIf4.regWSEL_ex   = regWSEL_ex;
    assign hzIf4.rs_dec       = rs_dec;
    assign hzIf4.rt_dec       = rt_dec;
    assign hzIf4.rt_used_dec  = rt_used_dec;
    assign hzIf4.redirect_mem = redirect_mem;
    assign hzIf4.halt_mem     = halt_mem;

    pipeline_hazard_ctrl #(.STALL_W(16)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .hz        (hzIf.master),
        .halted    (halted),
        .stall_cnt (stallCnt)
    );

    pipeline_hazard_ctrl #(.STALL_W(4)) dut4 (
        .CLK       (CLK),
        .RST       (RST),
        .hz        (hzIf4.master),
        .halted    (halted4),
        .stall_cnt (stallCnt4)
    );

    always #5 CLK = ~CLK;

    function automatic logic [8:0] ctrlVec();
        return {hzIf.pc_en, hzIf.en_fd, hzIf.en_de, hzIf.en_em, hzIf.en_mw,
                hzIf.flush_fd, hzIf.flush_de, hzIf.flush_em, hzIf.flush_mw};
    endfunction

    task automatic checkVal(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errorCount++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and step just past it to drive new inputs.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idleInputs();
        ihit = 1'b1; dhit = 1'b0; dREN_mem = 1'b0; dWEN_mem = 1'b0;
        dREN_ex = 1'b0; regWSEL_ex = '0; rs_dec = '0; rt_dec = '0;
        rt_used_dec = 1'b0; redirect_mem = 1'b0; halt_mem = 1'b0;
    endtask

    initial begin
        RST = 1'b1;
        idleInputs();

        // Reset: forced flush, counters cleared.
        @(negedge CLK);
        checkVal("reset_ctrl", 32'(ctrlVec()), 32'(V_RESET));
        tick();
        tick();
        checkVal("reset_halted", 32'(halted), 32'd0);
        checkVal("reset_cnt", 32'(stallCnt), 32'd0);
        RST = 1'b0;
        @(negedge CLK);
        checkVal("run_after_reset", 32'(ctrlVec()), 32'(V_RUN));

        // lw $2 in EX, add $3,$2,$4 in DEC: one bubble.
        tick();
        dREN_ex = 1'b1; regWSEL_ex = 5'd2; rs_dec = 5'd2; rt_dec = 5'd4;
        rt_used_dec = 1'b1;
        @(negedge CLK);
        checkVal("loaduse_rs", 32'(ctrlVec()), 32'(V_BUBBLE));
        tick();
        idleInputs();
        @(negedge CLK);
        checkVal("loaduse_release", 32'(ctrlVec()), 32'(V_RUN));
        checkVal("loaduse_cnt", 32'(stallCnt), 32'd1);

        // Same pattern with destination $0: no dependency.
        tick();
        dREN_ex = 1'b1; regWSEL_ex = 5'd0; rs_dec = 5'd0; rt_dec = 5'd0;
        rt_used_dec = 1'b1;
        @(negedge CLK);
        checkVal("loaduse_r0", 32'(ctrlVec()), 32'(V_RUN));

        // rt dependency only counts when rt is read.
        tick();
        regWSEL_ex = 5'd7; rs_dec = 5'd1; rt_dec = 5'd7; rt_used_dec = 1'b1;
        @(negedge CLK);
        checkVal("loaduse_rt", 32'(ctrlVec()), 32'(V_BUBBLE));
        tick();
        rt_used_dec = 1'b0;
        @(negedge CLK);
        checkVal("loaduse_rt_unused", 32'(ctrlVec()), 32'(V_RUN));
        checkVal("cnt_after_rt", 32'(stallCnt), 32'd2);

        // dmem miss for 3 cycles, then hit releases with full advance.
        tick();
        idleInputs();
        dREN_mem = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            checkVal($sformatf("dmiss_%0d", i), 32'(ctrlVec()), 32'(V_DMISS));
            tick();
        end
        dhit = 1'b1;
        @(negedge CLK);
        checkVal("dmiss_release", 32'(ctrlVec()), 32'(V_RUN));
        checkVal("dmiss_cnt", 32'(stallCnt), 32'd5);

        // Redirect with ihit low: target is still loaded.
        tick();
        idleInputs();
        ihit = 1'b0; redirect_mem = 1'b1;
        @(negedge CLK);
        checkVal("redirect_nohit", 32'(ctrlVec()), 32'(V_REDIR));
        tick();
        redirect_mem = 1'b0;
        @(negedge CLK);
        checkVal("imiss", 32'(ctrlVec()), 32'(V_BUBBLE));
        checkVal("redirect_cnt", 32'(stallCnt), 32'd5);

        // Load-use together with imem miss: same single bubble.
        tick();
        dREN_ex = 1'b1; regWSEL_ex = 5'd3; rs_dec = 5'd3;
        @(negedge CLK);
        checkVal("loaduse_and_imiss", 32'(ctrlVec()), 32'(V_BUBBLE));

        // Halt concurrent with dmem miss: halt path wins.
        tick();
        idleInputs();
        halt_mem = 1'b1; dREN_mem = 1'b1; dhit = 1'b0;
        @(negedge CLK);
        checkVal("halt_over_dmiss", 32'(ctrlVec()), 32'(V_HALT));
        tick();
        idleInputs();
        @(negedge CLK);
        checkVal("halt_drain", 32'(ctrlVec()), 32'(V_DRAIN));
        checkVal("drain_not_halted", 32'(halted), 32'd0);
        for (int i = 0; i < 100; i++) begin
            tick();
            ihit = i[0];
            redirect_mem = i[1];
            @(negedge CLK);
            checkVal($sformatf("halted_ctrl_%0d", i), 32'(ctrlVec()), 32'(V_IDLE));
            checkVal($sformatf("halted_flag_%0d", i), 32'(halted), 32'd1);
        end
        checkVal("halted_cnt", 32'(stallCnt), 32'd9);

        // Reset exits HALTED.
        tick();
        idleInputs();
        RST = 1'b1;
        @(negedge CLK);
        checkVal("reset_from_halt", 32'(ctrlVec()), 32'(V_RESET));
        tick();
        RST = 1'b0;
        @(negedge CLK);
        checkVal("run_after_halt", 32'(ctrlVec()), 32'(V_RUN));
        checkVal("halted_cleared", 32'(halted), 32'd0);

        // Reset during a dmem wait discards the pending miss.
        tick();
        dREN_mem = 1'b1;
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        dhit = 1'b0; dREN_mem = 1'b0;
        @(negedge CLK);
        checkVal("reset_mid_wait", 32'(ctrlVec()), 32'(V_RUN));
        checkVal("reset_mid_wait_cnt", 32'(stallCnt), 32'd0);

        // 20 imem-miss cycles: 4-bit counter saturates, 16-bit does not.
        ihit = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        @(negedge CLK);
        checkVal("sat_cnt4", 32'(stallCnt4), 32'd15);
        checkVal("nosat_cnt16", 32'(stallCnt), 32'd20);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1);
    end

endmodule
